// File: rtl/imem_boot_ctrl.sv
// Boot sequencer for the instruction memory: loads a word image from a byte
// stream, then hands the memory to the core's fetch port until a reload.
module imem_boot_ctrl #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid_i,
    input  logic [7:0]    in_data_i,
    output logic          in_ready_o,
    input  logic          load_req_i,
    input  logic          fetch_valid_i,
    input  logic [31:0]   fetch_addr_i,
    output logic          fetch_ready_o,
    output logic [31:0]   fetch_data_o,
    output logic          core_stall_o,
    output logic [31:0]   mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    output logic          mem_rw_o,
    input  logic [31:0]   mem_rdata_i,
    output logic          load_done_o,
    output logic [AW:0]   words_loaded_o
);

    typedef enum logic [1:0] {
        S_HEADER = 2'd0,
        S_BYTES  = 2'd1,
        S_WRITE  = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

    state_t      state_q, state_d;
    logic [AW:0] n_q, n_d;
    logic [AW:0] words_q, words_d;
    logic [1:0]  byte_q, byte_d;
    logic [31:0] asm_q, asm_d;
    logic        done_q, done_d;

    // Only the word-index bits of the fetch address reach the memory.
    logic unused_fetch_bits;
    assign unused_fetch_bits = ^{fetch_addr_i[31:AW+2], fetch_addr_i[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_HEADER;
            n_q     <= '0;
            words_q <= '0;
            byte_q  <= '0;
            asm_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            words_q <= words_d;
            byte_q  <= byte_d;
            asm_q   <= asm_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        n_d           = n_q;
        words_d       = words_q;
        byte_d        = byte_q;
        asm_d         = asm_q;
        in_ready_o    = 1'b0;
        core_stall_o  = 1'b1;
        fetch_ready_o = 1'b0;
        fetch_data_o  = '0;
        mem_rw_o      = 1'b1;
        mem_addr_o    = {{(32-AW){1'b0}}, words_q[AW-1:0]};
        mem_wdata_o   = asm_q;

        case (state_q)
            S_HEADER: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    // A zero count keeps the resident image and restarts the core.
                    if (in_data_i == 8'd0) begin
                        state_d = S_RUN;
                    end else begin
                        if (32'(in_data_i) > 32'(DEPTH))
                            n_d = DEPTH_N;
                        else
                            n_d = (AW+1)'(in_data_i);
                        words_d = '0;
                        byte_d  = '0;
                        state_d = S_BYTES;
                    end
                end
            end
            S_BYTES: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    asm_d[{byte_q, 3'b000} +: 8] = in_data_i;
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3)
                        state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_rw_o = 1'b0;
                words_d  = words_q + (AW+1)'(1);
                state_d  = (words_d == n_q) ? S_RUN : S_BYTES;
            end
            default: begin
                core_stall_o  = 1'b0;
                mem_addr_o    = {{(32-AW){1'b0}}, fetch_addr_i[AW+1:2]};
                fetch_ready_o = fetch_valid_i;
                fetch_data_o  = fetch_valid_i ? mem_rdata_i : 32'd0;
                if (load_req_i)
                    state_d = S_HEADER;
            end
        endcase

        done_d = (state_d == S_RUN) && (state_q != S_RUN);
    end

    assign load_done_o    = done_q;
    assign words_loaded_o = words_q;

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Sequencer and arbiter for the instruction memory. After reset it owns the memory write port and loads a program image from a byte stream (UART/debug loader). It then hands the memory to the core's fetch port and holds the core stalled until the load is complete. A reload can be requested at any time from RUN.

## Interface
Parameters:
- DEPTH, 64: instruction memory depth in words; maximum load length.
- AW, 6: word-address width, equal to clog2(DEPTH).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- in_valid  in  1  loader byte valid.
- in_data  in  8  loader byte.
- in_ready  out  1  controller accepts a byte when in_valid & in_ready.
- load_req  in  1  single-cycle pulse; requests a reload, honoured only in RUN.
- fetch_valid  in  1  core fetch request.
- fetch_addr  in  32  core byte address; bits [1:0] ignored.
- fetch_ready  out  1  fetch served this cycle.
- fetch_data  out  32  instruction word; 0 when fetch_ready=0.
- core_stall  out  1  high whenever the state is not RUN.
- mem_addr  out  32  word index to the memory; upper bits are zero.
- mem_wdata  out  32  write data.
- mem_rw  out  1  1 = read, 0 = write. The memory writes on a clock edge when mem_rw=0.
- mem_rdata  in  32  combinational read data.
- load_done  out  1  one-cycle pulse on entry to RUN.
- words_loaded  out  AW+1  words written in the current or last load.

## Operation
- States: HEADER, BYTES, WRITE, RUN.
- HEADER: in_ready=1. The accepted byte is N, the word count.
  - N=0: go to RUN, keeping the existing image.
  - N>DEPTH: N saturates to DEPTH.
  - Otherwise: go to BYTES. Clear the byte counter, the word counter and words_loaded.
- BYTES: in_ready=1.
  - Bytes are assembled little-endian: the first byte goes to [7:0] and the fourth to [31:24].
  - On acceptance of the 4th byte, go to WRITE.
- WRITE: lasts exactly one cycle.
  - Drives mem_rw=0, mem_addr=word counter, mem_wdata=assembled word. in_ready=0.
  - Then increment the word counter and words_loaded.
  - If the new count equals N, go to RUN. Otherwise go to BYTES.
- RUN: in_ready=0, core_stall=0.
  - mem_rw=1 and mem_addr={zeros, fetch_addr[AW+1:2]}.
  - fetch_ready=fetch_valid and fetch_data=mem_rdata, both combinational.
  - load_req=1 moves the state to HEADER on the next edge.
- Outside RUN: fetch_ready=0 and fetch_data=0 regardless of fetch_valid. mem_rw=1 in every state except WRITE.
- Bytes presented outside HEADER/BYTES are not consumed, because in_ready=0.
- load_req outside RUN is ignored.

## Timing
- Reset values:
  - state=HEADER, in_ready=1, core_stall=1.
  - fetch_ready=0, fetch_data=0.
  - mem_rw=1, mem_addr=0, mem_wdata=0.
  - load_done=0, words_loaded=0.
  - Internal counters and the assembly register are cleared.
- Load cost per word: 4 accepted bytes + 1 WRITE cycle, so at least 5 cycles per word. N words need at least 1 + 5N cycles from the header byte to RUN.
- load_done is high in the first RUN cycle only.
- core_stall falls in the same cycle the state becomes RUN. It rises in the cycle after load_req is sampled.
- Fetch in RUN has zero-cycle latency (combinational). Throughput is one fetch per cycle.
- A fetch coincident with load_req is served in that cycle; the stall begins next cycle.
- in_valid gaps: bytes may arrive with any number of idle cycles between them, and assembly state holds.
- Reset mid-load: the state returns to HEADER immediately. Memory keeps any words already written; no cleanup writes are issued. words_loaded=0.
- Word counter saturation: N≤DEPTH guarantees mem_addr < DEPTH.

## Test plan
- Reset, then header 0x02, bytes 93 80 10 00 13 01 11 00 -> WRITE at addr 0 with 0x00108093, then WRITE at addr 1 with 0x00110113. load_done pulses, core_stall falls, words_loaded=2.
- In RUN, fetch_valid=1, fetch_addr=0x4, memory returns 0x00110113 -> mem_addr=1, mem_rw=1, fetch_ready=1, fetch_data=0x00110113 in the same cycle.
- Header 0x00 -> RUN on the next cycle, no mem_rw=0 cycles, words_loaded unchanged at 0.
- Header 0xFF with DEPTH=64 -> exactly 64 WRITE cycles (addr 0..63), then RUN. in_ready=0 afterwards while in_valid stays high.
- load_req pulsed in RUN together with fetch_valid -> fetch served that cycle. Next cycle core_stall=1, fetch_ready=0, in_ready=1.
- reset asserted after 2 of 4 bytes of word 1 -> HEADER immediately. Word 0 is still in memory, no partial write occurs, words_loaded=0.
